float_to_int: RTL and testbench

//  Converts IEEE-754 binary32 to two's-complement int32, rounding toward zero (C cast).

---
 rtl/fpu_pkg.sv | 33 +++
 rtl/float_unpack.sv | 29 ++
 rtl/float_to_int.sv | 170 +++++++++++++++++
 tb/tb_float_to_int.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/fpu_pkg.sv
// fpu_pkg: shared binary32 field layout, integer limits and FSM encodings.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package fpu_pkg;

    // binary32 field layout
    localparam int F32_SIGN_BIT = 31;
    localparam int F32_EXP_MSB  = 30;
    localparam int F32_EXP_LSB  = 23;
    localparam int F32_FRAC_MSB = 22;

    localparam int                 F32_BIAS    = 127;
    localparam logic signed [9:0]  F32_BIAS_S  = 10'sd127;
    localparam logic [7:0]         F32_EXP_MAX = 8'd255;

    // Integer limits and the one binary32 value that converts exactly to INT32_MIN
    localparam logic [31:0] INT32_MIN    = 32'h8000_0000;
    localparam logic [31:0] INT32_MAX    = 32'h7FFF_FFFF;
    localparam logic [31:0] F32_NEG_2P31 = 32'hCF00_0000;

    // Unbiased exponent at which the working register holds the integer magnitude
    localparam logic signed [9:0] F2I_E_STOP = 10'sd31;

    typedef enum logic [2:0] {
        ST_GET_A   = 3'd0,
        ST_UNPACK  = 3'd1,
        ST_SPECIAL = 3'd2,
        ST_CONVERT = 3'd3,
        ST_PACK    = 3'd4,
        ST_PUT_Z   = 3'd5
    } f2i_state_t;

endpackage

// File: rtl/float_unpack.sv
// float_unpack: splits a binary32 word into sign, biased exponent, mantissa and class flags.
// Latency: combinational.
// Backpressure: none (pure function of the input word).
module float_unpack
    import fpu_pkg::*;
(
    input  logic [31:0] a,
    output logic        sign,
    output logic [7:0]  exp_biased,
    output logic [23:0] mant,
    output logic        is_zero_or_denorm,
    output logic        is_inf,
    output logic        is_nan
);

    logic [22:0] frac;

    // Field extraction and classification; the hidden bit is 0 only for zero/denormals
    always_comb begin
        sign              = a[F32_SIGN_BIT];
        exp_biased        = a[F32_EXP_MSB:F32_EXP_LSB];
        frac              = a[F32_FRAC_MSB:0];
        is_zero_or_denorm = (exp_biased == 8'd0);
        is_inf            = (exp_biased == F32_EXP_MAX) && (frac == 23'd0);
        is_nan            = (exp_biased == F32_EXP_MAX) && (frac != 23'd0);
        mant              = {~is_zero_or_denorm, frac};
    end

endmodule

// File: rtl/float_to_int.sv
// float_to_int: binary32 -> int32, rounding toward zero; one right shift per clock.
// Latency: result valid 2 edges after accept for special cases, 4+(31-E) edges otherwise (max 35).
// Backpressure: single operand in flight; input_a_ack stays low until output_z is taken.
// Build option: FLOAT_TO_INT_SATURATE_EN makes out-of-range results saturate by sign (NaN -> INT32_MIN).
module float_to_int
    import fpu_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] input_a,
    input  logic        input_a_stb,
    output logic        input_a_ack,
    output logic [31:0] output_z,
    output logic        output_z_stb,
    input  logic        output_z_ack
);

    f2i_state_t        state_q, state_d;
    logic [31:0]       a_q, a_d;
    logic              s_q, s_d;
    logic signed [9:0] e_q, e_d;
    logic [31:0]       m_q, m_d;
    logic              zd_q, zd_d;
    logic              inf_q, inf_d;
    logic              nan_q, nan_d;
    logic [31:0]       z_q, z_d;
    logic              z_stb_q, z_stb_d;
    logic              a_ack_q, a_ack_d;

    logic              u_sign;
    logic [7:0]        u_exp;
    logic [23:0]       u_mant;
    logic              u_zd, u_inf, u_nan;
    logic [31:0]       ovf_val;

    float_unpack u_unpack (
        .a                 (a_q),
        .sign              (u_sign),
        .exp_biased        (u_exp),
        .mant              (u_mant),
        .is_zero_or_denorm (u_zd),
        .is_inf            (u_inf),
        .is_nan            (u_nan)
    );

    // Result for operands outside the int32 range
    always_comb begin
`ifdef FLOAT_TO_INT_SATURATE_EN
        if (nan_q || s_q) begin
            ovf_val = INT32_MIN;
        end else begin
            ovf_val = INT32_MAX;
        end
`else
        ovf_val = INT32_MIN;
`endif
    end

    // Next-state and datapath: hold by default, each state updates only what it owns
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        s_d     = s_q;
        e_d     = e_q;
        m_d     = m_q;
        zd_d    = zd_q;
        inf_d   = inf_q;
        nan_d   = nan_q;
        z_d     = z_q;
        z_stb_d = z_stb_q;
        a_ack_d = a_ack_q;

        case (state_q)
            ST_GET_A: begin
                a_ack_d = 1'b1;
                if (a_ack_q && input_a_stb) begin
                    a_d     = input_a;
                    a_ack_d = 1'b0;
                    state_d = ST_UNPACK;
                end
            end
            ST_UNPACK: begin
                s_d     = u_sign;
                e_d     = $signed({2'b00, u_exp}) - F32_BIAS_S;
                m_d     = {u_mant, 8'd0};
                zd_d    = u_zd;
                inf_d   = u_inf;
                nan_d   = u_nan;
                state_d = ST_SPECIAL;
            end
            ST_SPECIAL: begin
                state_d = ST_PUT_Z;
                z_stb_d = 1'b1;
                if (zd_q || (e_q < 10'sd0)) begin
                    z_d = 32'd0;
                end else if (inf_q || nan_q) begin
                    z_d = ovf_val;
                end else if ((e_q > F2I_E_STOP) || ((e_q == F2I_E_STOP) && (a_q != F32_NEG_2P31))) begin
                    z_d = ovf_val;
                end else if (e_q == F2I_E_STOP) begin
                    // exactly -2^31 is representable
                    z_d = INT32_MIN;
                end else begin
                    state_d = ST_CONVERT;
                    z_stb_d = 1'b0;
                end
            end
            ST_CONVERT: begin
                // shift until the binary point sits below bit 0
                if (e_q < F2I_E_STOP) begin
                    m_d = m_q >> 1;
                    e_d = e_q + 10'sd1;
                end else begin
                    state_d = ST_PACK;
                end
            end
            ST_PACK: begin
                z_d     = s_q ? (-m_q) : m_q;
                z_stb_d = 1'b1;
                state_d = ST_PUT_Z;
            end
            ST_PUT_Z: begin
                if (output_z_ack) begin
                    z_stb_d = 1'b0;
                    a_ack_d = 1'b1;
                    state_d = ST_GET_A;
                end
            end
            default: begin
                state_d = ST_GET_A;
                z_stb_d = 1'b0;
                a_ack_d = 1'b0;
            end
        endcase
    end

    // State register; reset discards any operand or pending result
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_GET_A;
            a_q     <= 32'd0;
            s_q     <= 1'b0;
            e_q     <= 10'sd0;
            m_q     <= 32'd0;
            zd_q    <= 1'b0;
            inf_q   <= 1'b0;
            nan_q   <= 1'b0;
            z_q     <= 32'd0;
            z_stb_q <= 1'b0;
            a_ack_q <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            s_q     <= s_d;
            e_q     <= e_d;
            m_q     <= m_d;
            zd_q    <= zd_d;
            inf_q   <= inf_d;
            nan_q   <= nan_d;
            z_q     <= z_d;
            z_stb_q <= z_stb_d;
            a_ack_q <= a_ack_d;
        end
    end

    assign input_a_ack  = a_ack_q;
    assign output_z     = z_q;
    assign output_z_stb = z_stb_q;

endmodule

// File: tb/tb_float_to_int.sv
// tb_float_to_int: directed vector table, handshake corner sequences and a random run
// against a real-arithmetic C-cast model.
module tb_float_to_int;
    import fpu_pkg::*;

`ifdef FLOAT_TO_INT_SATURATE_EN
    localparam logic [31:0] OVF_POS = 32'h7FFF_FFFF;
`else
    localparam logic [31:0] OVF_POS = 32'h8000_0000;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] input_a = 32'd0;
    logic        input_a_stb = 1'b0;
    logic        input_a_ack;
    logic [31:0] output_z;
    logic        output_z_stb;
    logic        output_z_ack = 1'b0;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    float_to_int dut (
        .clk          (clk),
        .rst          (rst),
        .input_a      (input_a),
        .input_a_stb  (input_a_stb),
        .input_a_ack  (input_a_ack),
        .output_z     (output_z),
        .output_z_stb (output_z_stb),
        .output_z_ack (output_z_ack)
    );

    typedef struct {
        logic [31:0] a;
        logic [31:0] z;
        int          lat;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // C-cast reference: value computed as a real, range-checked, then truncated
    function automatic logic [31:0] model(input logic [31:0] a, output int lat);
        int  ex;
        int  e;
        real v;
        logic [22:0] frac;
        logic sgn;
        logic [31:0] ovf;
        ex   = int'(a[30:23]);
        frac = a[22:0];
        sgn  = a[31];
        ovf  = sgn ? 32'h8000_0000 : OVF_POS;
        lat  = 2;
        if (ex == 255) return (frac != 23'd0) ? 32'h8000_0000 : ovf;
        if (ex == 0) return 32'd0;
        e = ex - 127;
        if (e < 0) return 32'd0;
        v = 1.0 + real'(frac) / 8388608.0;
        for (int i = 0; i < e; i++) v = v * 2.0;
        if (sgn) v = -v;
        if (v == -2147483648.0) return 32'h8000_0000;
        if ((v >= 2147483648.0) || (v < -2147483648.0)) return ovf;
        lat = 4 + (31 - e);
        return 32'($rtoi(v));
    endfunction

    // Present one operand; returns at the negedge after the accepting edge (edge 0)
    task automatic accept(input logic [31:0] a);
        int n;
        n = 0;
        while (input_a_ack !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (input_a_ack !== 1'b1) begin
            check("accept_timeout", {31'd0, input_a_ack}, 32'd1);
            return;
        end
        input_a     = a;
        input_a_stb = 1'b1;
        @(posedge clk);
        @(negedge clk);
        input_a_stb = 1'b0;
    endtask

    // Count edges after edge 0 until output_z_stb is seen; also count ack-high cycles meanwhile
    task automatic wait_result(output int lat, output int ack_hi);
        lat    = 0;
        ack_hi = 0;
        while (output_z_stb !== 1'b1 && lat < 100) begin
            if (input_a_ack !== 1'b0) ack_hi++;
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic take(input int delay);
        repeat (delay) @(negedge clk);
        output_z_ack = 1'b1;
        @(posedge clk);
        @(negedge clk);
        output_z_ack = 1'b0;
    endtask

    task automatic run_vec(input string name, input logic [31:0] a, input logic [31:0] z, input int lat);
        int got_lat;
        int ack_hi;
        accept(a);
        wait_result(got_lat, ack_hi);
        check({name, "_z"}, output_z, z);
        check({name, "_lat"}, 32'(got_lat), 32'(lat));
        check({name, "_ack_low"}, 32'(ack_hi), 32'd0);
        take(0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1);
    end

    initial begin
        vec_t vecs[$];
        int   lat;
        int   ack_hi;
        int   bad;
        int   seen;
        logic [31:0] a;
        logic [31:0] exp_z;

        vecs.push_back('{32'h3F80_0000, 32'h0000_0001, 35});
        vecs.push_back('{32'hC020_0000, 32'hFFFF_FFFE, 34});
        vecs.push_back('{32'h3F40_0000, 32'h0000_0000, 2});
        vecs.push_back('{32'h0000_0001, 32'h0000_0000, 2});
        vecs.push_back('{32'h0000_0000, 32'h0000_0000, 2});
        vecs.push_back('{32'h8000_0000, 32'h0000_0000, 2});
        vecs.push_back('{32'hCF00_0000, 32'h8000_0000, 2});
        vecs.push_back('{32'hCF00_0001, 32'h8000_0000, 2});
        vecs.push_back('{32'h4F00_0000, OVF_POS,       2});
        vecs.push_back('{32'h7F80_0000, OVF_POS,       2});
        vecs.push_back('{32'hFF80_0000, 32'h8000_0000, 2});
        vecs.push_back('{32'h7FC0_0000, 32'h8000_0000, 2});
        vecs.push_back('{32'h42F6_0000, 32'h0000_007B, 29});
        vecs.push_back('{32'h4EFF_FFFF, 32'h7FFF_FF80, 5});
        vecs.push_back('{32'hCEFF_FFFF, 32'h8000_0080, 5});

        // reset state
        repeat (3) @(negedge clk);
        check("rst_z", output_z, 32'd0);
        check("rst_stb", {31'd0, output_z_stb}, 32'd0);
        check("rst_ack", {31'd0, input_a_ack}, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("ack_after_rst", {31'd0, input_a_ack}, 32'd1);

        // directed table
        foreach (vecs[i]) begin
            run_vec($sformatf("vec%0d", i), vecs[i].a, vecs[i].z, vecs[i].lat);
        end

        // backpressure: hold the result, stray operand strobe ignored
        accept(32'h4049_0FDB);
        wait_result(lat, ack_hi);
        check("bp_z", output_z, 32'd3);
        check("bp_lat", 32'(lat), 32'd34);
        input_a     = 32'h1234_5678;
        input_a_stb = 1'b1;
        bad = 0;
        repeat (10) begin
            @(negedge clk);
            if (output_z_stb !== 1'b1 || output_z !== 32'd3 || input_a_ack !== 1'b0) bad++;
        end
        check("bp_hold", 32'(bad), 32'd0);
        input_a_stb  = 1'b0;
        output_z_ack = 1'b1;
        @(posedge clk);
        @(negedge clk);
        output_z_ack = 1'b0;
        check("bp_stb_drop", {31'd0, output_z_stb}, 32'd0);
        check("bp_ack_rise", {31'd0, input_a_ack}, 32'd1);

        // reset in the middle of the shift loop
        accept(32'h3F80_0000);
        repeat (10) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("midrst_z", output_z, 32'd0);
        check("midrst_stb", {31'd0, output_z_stb}, 32'd0);
        check("midrst_ack", {31'd0, input_a_ack}, 32'd0);
        rst  = 1'b0;
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (output_z_stb !== 1'b0) seen++;
        end
        check("midrst_no_result", 32'(seen), 32'd0);
        check("midrst_ack_back", {31'd0, input_a_ack}, 32'd1);
        run_vec("after_rst", 32'h42F6_0000, 32'h0000_007B, 29);

        // random run against the model, with stray early acks and random sink delays
        for (int n = 0; n < 250; n++) begin
            int exp_lat;
            if ($urandom_range(0, 7) == 0) begin
                a = $urandom;
            end else begin
                a = {1'($urandom_range(0, 1)), 8'($urandom_range(110, 162)), 23'($urandom)};
            end
            exp_z = model(a, exp_lat);
            if ($urandom_range(0, 3) == 0) output_z_ack = 1'b1;
            accept(a);
            wait_result(lat, ack_hi);
            check($sformatf("rnd%0d_z a=%h", n, a), output_z, exp_z);
            check($sformatf("rnd%0d_lat a=%h", n, a), 32'(lat), 32'(exp_lat));
            take(output_z_ack ? 0 : int'($urandom_range(0, 3)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
